// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU command encoding, command width and sequencer state encoding shared by the ALU and sequencer.
package cpu_pkg;
    localparam int CMD_WIDTH = 3;
    typedef logic [CMD_WIDTH-1:0] cmd_t;
    localparam cmd_t CMD_NOP = 3'd0;
    localparam cmd_t CMD_ADD = 3'd1;
    localparam cmd_t CMD_SUB = 3'd2;
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
    function automatic logic is_arith(cmd_t c);
        return c == CMD_ADD || c == CMD_SUB;
    endfunction
    function automatic logic is_legal(cmd_t c);
        return c <= CMD_SUB;
    endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction-source side of the sequencer.
// Carries the operation offer (opValid/opReady, opCmd, opRd, opRs1, opRs2),
// the completion report (doneValid, doneRd, doneData) and the sticky errIllegal flag.
// master = instruction source, slave = sequencer.
interface alu_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 5
);
    import cpu_pkg::*;
    logic                  opValid;
    logic                  opReady;
    cmd_t                  opCmd;
    logic [SEL_WIDTH-1:0]  opRd;
    logic [SEL_WIDTH-1:0]  opRs1;
    logic [SEL_WIDTH-1:0]  opRs2;
    logic                  doneValid;
    logic [SEL_WIDTH-1:0]  doneRd;
    logic [DATA_WIDTH-1:0] doneData;
    logic                  errIllegal;
    modport master (
        output opValid, opCmd, opRd, opRs1, opRs2,
        input  opReady, doneValid, doneRd, doneData, errIllegal
    );
    modport slave (
        input  opValid, opCmd, opRd, opRs1, opRs2,
        output opReady, doneValid, doneRd, doneData, errIllegal
    );
endinterface

// File: rtl/alu.sv
// alu: combinational ADD/SUB unit; NOP and unknown commands yield zero.
// Ports: cmd (command), lhs/rhs (operands), result (modulo 2^DATA_WIDTH).
import cpu_pkg::*;

module alu #(
    parameter int DATA_WIDTH = 32
) (
    input  cmd_t                  cmd,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic [DATA_WIDTH-1:0] rhs,
    output logic [DATA_WIDTH-1:0] result
);
    always_comb begin
        result = (cmd == CMD_ADD) ? lhs + rhs :
                 (cmd == CMD_SUB) ? lhs - rhs : '0;
    end
endmodule

// File: rtl/register_file.sv
// register_file: two registered read ports, one write port, plus a debug port for preload/inspection.
// Ports: clk; reg1Sel/reg2Sel -> reg1/reg2 (one-cycle latency); regWSel/regWData/regWWe write;
// dbgWe/dbgSel/dbgWData debug write (has priority), dbgRData combinational debug read of dbgSel.
// r0 has no storage and always reads zero.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic [SEL_WIDTH-1:0]  reg1Sel,
    input  logic [SEL_WIDTH-1:0]  reg2Sel,
    output logic [DATA_WIDTH-1:0] reg1,
    output logic [DATA_WIDTH-1:0] reg2,
    input  logic [SEL_WIDTH-1:0]  regWSel,
    input  logic [DATA_WIDTH-1:0] regWData,
    input  logic                  regWWe,
    input  logic                  dbgWe,
    input  logic [SEL_WIDTH-1:0]  dbgSel,
    input  logic [DATA_WIDTH-1:0] dbgWData,
    output logic [DATA_WIDTH-1:0] dbgRData
);
    logic [DATA_WIDTH-1:0] mem [2**SEL_WIDTH];
    always_ff @(posedge clk) begin
        if (dbgWe && dbgSel != '0)
            mem[dbgSel] <= dbgWData;
        else if (regWWe && regWSel != '0)
            mem[regWSel] <= regWData;
        reg1 <= (reg1Sel == '0) ? '0 : mem[reg1Sel];
        reg2 <= (reg2Sel == '0) ? '0 : mem[reg2Sel];
    end
    assign dbgRData = (dbgSel == '0) ? '0 : mem[dbgSel];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: runs one register-to-register ALU op at a time (IDLE -> READ -> EXEC -> WB).
// Ports: clk, reset (sync, active-high); op (slave side of alu_sequencer_if: offer, done, errIllegal);
// reg1Sel/reg2Sel + reg1/reg2 register file reads; regWSel/regWData/regWWe write-back;
// aluCmd/aluLhs/aluRhs + aluResult ALU connection.
import cpu_pkg::*;

module alu_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_sequencer_if.slave        op,
    output logic [SEL_WIDTH-1:0]  reg1Sel,
    output logic [SEL_WIDTH-1:0]  reg2Sel,
    input  logic [DATA_WIDTH-1:0] reg1,
    input  logic [DATA_WIDTH-1:0] reg2,
    output logic [SEL_WIDTH-1:0]  regWSel,
    output logic [DATA_WIDTH-1:0] regWData,
    output logic                  regWWe,
    output cmd_t                  aluCmd,
    output logic [DATA_WIDTH-1:0] aluLhs,
    output logic [DATA_WIDTH-1:0] aluRhs,
    input  logic [DATA_WIDTH-1:0] aluResult
);
    state_t                state, state_nx;
    cmd_t                  cmd_q;
    logic [SEL_WIDTH-1:0]  rd_q, rs1_q, rs2_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cmd_q    <= CMD_NOP;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && op.opValid) begin
                cmd_q <= op.opCmd;
                rd_q  <= op.opRd;
                rs1_q <= op.opRs1;
                rs2_q <= op.opRs2;
            end
            // NOP and illegal ops report zero regardless of what the ALU returns
            if (state == EXEC)
                result_q <= is_arith(cmd_q) ? aluResult : '0;
            if (state == WB && !is_legal(cmd_q))
                err_q <= 1'b1;
        end
    end
    always_comb begin
        state_nx = IDLE;
        state_nx = (state == IDLE) ? (op.opValid ? READ : IDLE) :
                   (state == READ) ? EXEC :
                   (state == EXEC) ? WB : IDLE;
    end
    always_comb begin
        op.opReady   = (state == IDLE);
        reg1Sel      = rs1_q;
        reg2Sel      = rs2_q;
        aluCmd       = (state == EXEC && is_legal(cmd_q)) ? cmd_q : CMD_NOP;
        aluLhs       = (state == EXEC) ? reg1 : '0;
        aluRhs       = (state == EXEC) ? reg2 : '0;
        regWSel      = (state == WB) ? rd_q : '0;
        regWData     = (state == WB) ? result_q : '0;
        regWWe       = (state == WB) && is_arith(cmd_q) && (rd_q != '0);
        op.doneValid = (state == WB);
        op.doneRd    = (state == WB) ? rd_q : '0;
        op.doneData  = (state == WB) ? result_q : '0;
        op.errIllegal = err_q;
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: alu_sequencer with alu and register_file, table-driven ops plus back-to-back and mid-op reset sequences.
import cpu_pkg::*;

module tb_alu_sequencer;
    localparam int DW = 32;
    localparam int SW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_sequencer_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus();

    logic [SW-1:0] reg1Sel, reg2Sel, regWSel, dbgSel;
    logic [DW-1:0] reg1, reg2, regWData, aluLhs, aluRhs, aluResult, dbgWData, dbgRData;
    logic          regWWe, dbgWe;
    cmd_t          aluCmd;

    alu_sequencer #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
        .clk(clk), .reset(reset), .op(bus.slave),
        .reg1Sel(reg1Sel), .reg2Sel(reg2Sel), .reg1(reg1), .reg2(reg2),
        .regWSel(regWSel), .regWData(regWData), .regWWe(regWWe),
        .aluCmd(aluCmd), .aluLhs(aluLhs), .aluRhs(aluRhs), .aluResult(aluResult)
    );

    alu #(.DATA_WIDTH(DW)) u_alu (
        .cmd(aluCmd), .lhs(aluLhs), .rhs(aluRhs), .result(aluResult)
    );

    register_file #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) u_rf (
        .clk(clk), .reg1Sel(reg1Sel), .reg2Sel(reg2Sel), .reg1(reg1), .reg2(reg2),
        .regWSel(regWSel), .regWData(regWData), .regWWe(regWWe),
        .dbgWe(dbgWe), .dbgSel(dbgSel), .dbgWData(dbgWData), .dbgRData(dbgRData)
    );

    typedef struct {
        cmd_t          cmd;
        logic [SW-1:0] rd, rs1, rs2;
        cmd_t          exp_alu;
        logic [DW-1:0] exp_data;
        logic          exp_we;
        logic [DW-1:0] exp_reg;
        logic          exp_err;
    } vec_t;

    vec_t vecs [6];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [SW-1:0] s, input logic [DW-1:0] d);
        @(negedge clk);
        dbgSel = s; dbgWData = d; dbgWe = 1'b1;
        @(negedge clk);
        dbgWe = 1'b0;
    endtask

    task automatic peek(input logic [SW-1:0] s, output logic [DW-1:0] v);
        dbgSel = s;
        #1 v = dbgRData;
    endtask

    task automatic offer(input cmd_t c, input logic [SW-1:0] rd, rs1, rs2);
        bus.opValid = 1'b1; bus.opCmd = c; bus.opRd = rd; bus.opRs1 = rs1; bus.opRs2 = rs2;
    endtask

    task automatic wait_done(output int lat, output logic [DW-1:0] data, output logic [SW-1:0] drd,
                             output logic saw_we, output cmd_t exec_cmd);
        lat = 0; saw_we = 1'b0; exec_cmd = '1; data = 'x; drd = 'x;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            saw_we |= regWWe;
            if (lat == 2) exec_cmd = aluCmd;
            if (bus.doneValid) begin
                data = bus.doneData;
                drd = bus.doneRd;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int            lat, k;
        logic [DW-1:0] data, rv, a_data;
        logic [SW-1:0] drd;
        logic          saw_we, saw_done;
        cmd_t          exec_cmd;

        vecs[0] = '{CMD_ADD, 5'd4, 5'd1, 5'd2, CMD_ADD, 32'd10,        1'b1, 32'd10,        1'b0};
        vecs[1] = '{CMD_SUB, 5'd5, 5'd2, 5'd1, CMD_SUB, 32'hFFFFFFFC,  1'b1, 32'hFFFFFFFC,  1'b0};
        vecs[2] = '{CMD_ADD, 5'd0, 5'd1, 5'd2, CMD_ADD, 32'd10,        1'b0, 32'd0,         1'b0};
        vecs[3] = '{CMD_NOP, 5'd7, 5'd1, 5'd2, CMD_NOP, 32'd0,         1'b0, 32'h55,        1'b0};
        vecs[4] = '{3'd5,    5'd8, 5'd1, 5'd2, CMD_NOP, 32'd0,         1'b0, 32'h66,        1'b1};
        vecs[5] = '{CMD_ADD, 5'd9, 5'd1, 5'd2, CMD_ADD, 32'd10,        1'b1, 32'd10,        1'b1};

        dbgWe = 1'b0; dbgSel = '0; dbgWData = '0;
        offer(CMD_ADD, 5'd4, 5'd1, 5'd2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.opValid = 1'b0;
        #1;
        check("reset_opReady", 32'(bus.opReady), 32'd1);
        check("reset_doneValid", 32'(bus.doneValid), 32'd0);
        check("reset_regWWe", 32'(regWWe), 32'd0);
        check("reset_errIllegal", 32'(bus.errIllegal), 32'd0);
        check("reset_aluCmd", 32'(aluCmd), 32'd0);
        check("reset_sels", 32'({reg1Sel, reg2Sel, regWSel}), 32'd0);

        poke(5'd1, 32'd7);
        poke(5'd2, 32'd3);
        poke(5'd7, 32'h55);
        poke(5'd8, 32'h66);
        poke(5'd9, 32'd0);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("v%0d_ready", i), 32'(bus.opReady), 32'd1);
            offer(vecs[i].cmd, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
            @(posedge clk);
            #1 bus.opValid = 1'b0;
            wait_done(lat, data, drd, saw_we, exec_cmd);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("v%0d_aluCmd", i), 32'(exec_cmd), 32'(vecs[i].exp_alu));
            check($sformatf("v%0d_doneRd", i), 32'(drd), 32'(vecs[i].rd));
            check($sformatf("v%0d_doneData", i), data, vecs[i].exp_data);
            check($sformatf("v%0d_regWWe", i), 32'(saw_we), 32'(vecs[i].exp_we));
            @(negedge clk);
            peek(vecs[i].rd, rv);
            check($sformatf("v%0d_reg", i), rv, vecs[i].exp_reg);
            check($sformatf("v%0d_errIllegal", i), 32'(bus.errIllegal), 32'(vecs[i].exp_err));
        end

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 check("err_cleared_by_reset", 32'(bus.errIllegal), 32'd0);

        // dependent back-to-back: r3 = r1 + r2, then r6 = r3 + r3 with opValid held
        @(negedge clk);
        offer(CMD_ADD, 5'd3, 5'd1, 5'd2);
        @(posedge clk);
        #1 offer(CMD_ADD, 5'd6, 5'd3, 5'd3);
        k = 0; a_data = 'x;
        while (k < 10) begin
            @(negedge clk);
            k++;
            if (bus.doneValid) a_data = bus.doneData;
            if (bus.opReady) break;
        end
        check("b2b_gap", 32'(k), 32'd4);
        check("b2b_first_data", a_data, 32'd10);
        @(posedge clk);
        #1 bus.opValid = 1'b0;
        wait_done(lat, data, drd, saw_we, exec_cmd);
        check("b2b_latency", 32'(lat), 32'd3);
        check("b2b_doneRd", 32'(drd), 32'd6);
        check("b2b_doneData", data, 32'd20);
        @(negedge clk);
        peek(5'd6, rv);
        check("b2b_r6", rv, 32'd20);

        // reset while in EXEC drops the op
        poke(5'd4, 32'hDEAD);
        @(negedge clk);
        offer(CMD_ADD, 5'd4, 5'd1, 5'd2);
        @(posedge clk);
        #1 bus.opValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_exec_aluCmd", 32'(aluCmd), 32'(CMD_ADD));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        saw_done = bus.doneValid;
        saw_we = regWWe;
        @(negedge clk);
        check("rst_opReady_after", 32'(bus.opReady), 32'd1);
        repeat (4) begin
            saw_done |= bus.doneValid;
            saw_we |= regWWe;
            @(negedge clk);
        end
        check("rst_no_done", 32'(saw_done), 32'd0);
        check("rst_no_write", 32'(saw_we), 32'd0);
        peek(5'd4, rv);
        check("rst_r4_kept", rv, 32'hDEAD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that executes one register-to-register ALU operation at a time. It accepts an operation (opcode, destination, two sources) over a valid/ready handshake and sequences the register file read, the ALU evaluation and the register file write-back. It reports completion with a one-cycle done pulse. It sits between the instruction source and the `alu`/`register_file` pair and is the only driver of their control inputs.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width; must match ALU and register file.
- `SEL_WIDTH`, 5, register select width.

Ports:
- `clk` input 1: single clock; all state changes on posedge.
- `reset` input 1: synchronous, active-high.
- `opValid` input 1: operation offered.
- `opReady` output 1: sequencer can accept; high only in IDLE.
- `opCmd` input 3: ALU command (0 NOP, 1 ADD, 2 SUB; 3–7 illegal).
- `opRd` input SEL_WIDTH: destination register.
- `opRs1` input SEL_WIDTH: lhs source register.
- `opRs2` input SEL_WIDTH: rhs source register.
- `reg1Sel`, `reg2Sel` output SEL_WIDTH: register file read selects.
- `reg1`, `reg2` input DATA_WIDTH: register file read data (registered inside the register file, one-cycle latency).
- `regWSel` output SEL_WIDTH, `regWData` output DATA_WIDTH, `regWWe` output 1: register file write port.
- `aluCmd` output 3, `aluLhs` output DATA_WIDTH, `aluRhs` output DATA_WIDTH: ALU inputs.
- `aluResult` input DATA_WIDTH: ALU combinational result.
- `doneValid` output 1: one-cycle completion pulse.
- `doneRd` output SEL_WIDTH, `doneData` output DATA_WIDTH: destination and result of the completed operation.
- `errIllegal` output 1: sticky; set by an illegal opcode, cleared only by reset.

## Operation
- States: IDLE → READ → EXEC → WB → IDLE.
- **IDLE**: `opReady`=1. On `opValid&opReady`, latch `opCmd`/`opRd`/`opRs1`/`opRs2` into internal registers, drive `reg1Sel`/`reg2Sel` from the latched sources, and go to READ.
- **READ**: selects held stable. The register file captures `reg1`/`reg2` at the end of this cycle. Go to EXEC.
- **EXEC**: `aluCmd`=latched cmd, `aluLhs`=`reg1`, `aluRhs`=`reg2`. Capture `aluResult` into the result register at the end of the cycle. Go to WB.
- **WB**: `regWSel`=latched rd and `regWData`=result register. `regWWe`=1 only if the cmd is ADD/SUB and rd≠0. `doneValid`=1, `doneRd`=rd, `doneData`=result. Go to IDLE.
- Writes to register 0 are always suppressed (r0 reads as zero and has no storage). `doneValid` still pulses, with `doneData` = computed result.
- NOP: no write, `doneValid` pulses, `doneData`=0.
- Illegal cmd (3–7): `aluCmd` is driven as NOP (0), no write, `doneValid` pulses with `doneData`=0, and `errIllegal` is set in WB.
- Arithmetic is modulo 2^DATA_WIDTH; the ALU owns it. The sequencer does no width extension.
- Outside EXEC, `aluCmd`=0 and `aluLhs`/`aluRhs`=0. Outside WB, `regWWe`=0 and `doneValid`=0.

## Timing
- Accept at edge N (end of IDLE cycle). READ is cycle N+1, EXEC is N+2, WB is N+3. The write commits at the end of N+3.
- Next accept is possible at the end of N+4. Throughput is one operation per 4 cycles.
- Back-to-back dependency (rd of op A = rs of op B): B's READ cycle is at least N+5, after A's commit, so there is no hazard and no forwarding is needed.
- `opReady` is a registered state decode. It does not depend combinationally on `opValid`.
- Reset (any state, including mid-operation) returns to IDLE at the next edge. Outputs after reset: `opReady`=1; `regWWe`, `doneValid`, `errIllegal`=0; all selects, data and `aluCmd`=0. The in-flight operation is dropped with no write and no done pulse.
- `opValid` asserted during reset is ignored. The first accept is possible in the first cycle after reset deasserts.

## Structure
- Shared package `cpu_pkg`: ALU command constants (NOP=0, ADD=1, SUB=2), the `CMD_WIDTH`=3 constant, and the state encoding (IDLE, READ, EXEC, WB).
- The package replaces per-file command macros; `alu` moves to it in the same change.
- No sub-module needed. The block is one FSM plus operand and result registers. The bench instantiates `alu`, `register_file` and `alu_sequencer` together.

## Test plan
- Reset, then preload r1=7 and r2=3 via a bench backdoor. Issue ADD rd=4, rs1=1, rs2=2 → `doneValid` pulses 3 cycles after accept with `doneRd`=4, `doneData`=10, and r4 reads 10.
- SUB rd=5, rs1=2, rs2=1 with r1=7, r2=3 → `doneData`=0xFFFFFFFC, r5=0xFFFFFFFC (wrap-around).
- ADD rd=0, rs1=1, rs2=2 → `regWWe` never asserts, `doneData`=10, and a subsequent read of r0 returns 0.
- opCmd=5 → `aluCmd` stays 0, no write, `doneValid` with `doneData`=0, `errIllegal`=1 and it remains 1 until reset.
- Dependent back-to-back: ADD r3=r1+r2 (=10), then ADD r6=r3+r3 offered with `opValid` held high → second accepted 4 cycles after the first, `doneData`=20.
- Assert `reset` in EXEC of ADD rd=4 → no write to r4, no `doneValid`, `opReady`=1 the cycle after reset deasserts.
